// File: rtl/seqdet_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//
// Contents:
//   calc_len_w()  width of a length/progress field able to hold 0..max_len
//   DEF_*         default geometry and reset-time pattern/length
//   len_t         length/progress field for the default geometry
//   pattern_t     pattern/history field for the default geometry
package seqdet_pkg;

  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = calc_len_w(DEF_MAX_LEN);

  // Legacy "1100" detector behaviour out of reset.
  localparam logic [DEF_MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1100;
  localparam int                     DEF_LEN     = 4;

  typedef logic [DEF_LEN_W-1:0]   len_t;
  typedef logic [DEF_MAX_LEN-1:0] pattern_t;

endpackage

// File: rtl/seqdet_prefix_calc.sv
// Longest-prefix search for the pattern detector (purely combinational).
//
// Given the history register before the new bit is shifted in, the number of
// valid history bits, the programmed pattern/length and the incoming bit,
// returns the largest j (0..min(len, hv+1)) for which the newest j history
// bits, taken after the shift, equal the first j pattern bits.
//
// Ports:
//   hist     in   MAX_LEN  history, newest bit in bit 0 (before shift)
//   hv       in   LEN_W    valid history bits before the shift
//   pattern  in   MAX_LEN  first expected bit is pattern[len-1]
//   len      in   LEN_W    programmed pattern length (already clamped)
//   b        in   1        bit being accepted this cycle
//   cand     out  LEN_W    longest matched prefix after accepting b
module seqdet_prefix_calc
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [LEN_W-1:0]   hv,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               b,
  output logic [LEN_W-1:0]   cand
);

  localparam logic [MAX_LEN-1:0] ALL_ONES = '1;

  logic [MAX_LEN-1:0] new_hist;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] pfx;

  // The oldest history bit falls off the end on every shift and never takes
  // part in a comparison.
  logic unused_hist_msb;
  assign unused_hist_msb = hist[MAX_LEN-1];

  assign new_hist = {hist[MAX_LEN-2:0], b};

  // For a candidate j, the first j pattern bits are pattern[len-1 -: j];
  // shifting right by len-j lines them up with new_hist[j-1:0]. Ascending j
  // with a later hit overwriting an earlier one gives priority to the
  // longest prefix.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so
    // no path leaves one unassigned and no latch is inferred.
    cand = '0;
    mask = '0;
    pfx  = '0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      mask = ALL_ONES >> (MAX_LEN - j);
      pfx  = pattern >> (len - LEN_W'(j));
      if ((j <= int'(len)) && (j <= int'(hv) + 1) &&
          (((new_hist ^ pfx) & mask) == '0)) begin
        cand = LEN_W'(j);
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial bit-pattern detector with a registered
// one-cycle (Moore-style) match pulse.
//
// Optional build macro: SEQDET_MATCH_CNT_EN
//   defined   -> match_count is a saturating count of detected pulses,
//                cleared by rst and cfg_we
//   undefined -> no counter logic; match_count is tied to 0
//
// Ports:
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous active-high reset
//   seqIn        in   1        serial data bit
//   in_valid     in   1        seqIn is accepted only when high
//   overlap_en   in   1        1: keep history after a match (overlapping)
//                              0: restart the search after a match
//   cfg_we       in   1        load cfg_pattern/cfg_len (wins over in_valid)
//   cfg_pattern  in   MAX_LEN  first expected bit cfg_pattern[cfg_len-1]
//   cfg_len      in   LEN_W    pattern length; >MAX_LEN clamps, 0 disables
//   detected     out  1        one-cycle pulse after the completing bit
//   progress     out  LEN_W    current matched-prefix length
//   match_count  out  CNT_W    saturating match count (optional feature)
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int                 MAX_LEN         = DEF_MAX_LEN,
  parameter int                 LEN_W           = calc_len_w(MAX_LEN),
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int                 DEFAULT_LEN     = DEF_LEN,
  parameter int                 CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seqIn,
  input  logic               in_valid,
  input  logic               overlap_en,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               detected,
  output logic [LEN_W-1:0]   progress,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q, pattern_nxt;
  logic [LEN_W-1:0]   len_q,     len_nxt;
  logic [MAX_LEN-1:0] hist_q,    hist_nxt;
  logic [LEN_W-1:0]   hv_q,      hv_nxt;
  logic [LEN_W-1:0]   progress_q, progress_nxt;
  logic               detected_q, detected_nxt;
  logic [LEN_W-1:0]   cand;

  seqdet_prefix_calc #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_prefix_calc (
    .hist    (hist_q),
    .hv      (hv_q),
    .pattern (pattern_q),
    .len     (len_q),
    .b       (seqIn),
    .cand    (cand)
  );

  // Next-state logic. Configuration wins over data; seqIn is dropped on a
  // cfg_we cycle. The pulse is the registered result of the previous
  // cycle, so it defaults low and is set only on a completing bit.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see
    // the values just computed; the registers below use '<=' so every
    // flop samples the pre-edge state.
    pattern_nxt  = pattern_q;
    len_nxt      = len_q;
    hist_nxt     = hist_q;
    hv_nxt       = hv_q;
    progress_nxt = progress_q;
    detected_nxt = 1'b0;

    if (cfg_we) begin
      pattern_nxt  = cfg_pattern;
      len_nxt      = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      progress_nxt = '0;
      hv_nxt       = '0;
    end else if (in_valid) begin
      hist_nxt = {hist_q[MAX_LEN-2:0], seqIn};
      hv_nxt   = (hv_q == LEN_MAX) ? hv_q : hv_q + LEN_W'(1);

      if (len_q == '0) begin
        // Zero length disables the detector: cand would trivially equal 0.
        progress_nxt = '0;
      end else if (cand == len_q) begin
        detected_nxt = 1'b1;
        if (overlap_en) begin
          progress_nxt = len_q;
        end else begin
          progress_nxt = '0;
          hv_nxt       = '0;
        end
      end else begin
        progress_nxt = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q  <= DEFAULT_PATTERN;
      len_q      <= LEN_W'(DEFAULT_LEN);
      hv_q       <= '0;
      progress_q <= '0;
      detected_q <= 1'b0;
    end else begin
      pattern_q  <= pattern_nxt;
      len_q      <= len_nxt;
      hv_q       <= hv_nxt;
      progress_q <= progress_nxt;
      detected_q <= detected_nxt;
    end
  end

  // NOTE: the history shift register has no reset; hv is cleared instead
  // and the prefix search ignores any history bit beyond hv.
  always_ff @(posedge clk) begin
    hist_q <= hist_nxt;
  end

  assign detected = detected_q;
  assign progress = progress_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || cfg_we) begin
      cnt_q <= '0;
    end else if (detected_q && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param. A table of per-cycle vectors
// (inputs plus expected detected/progress after the edge) is applied in a
// loop, followed by hand-written gap, disabled-length and counting runs.
// Expected values are queued when a cycle is driven and compared when the
// DUT has clocked it. The match_count expectation follows SEQDET_MATCH_CNT_EN.
module tb_seq_detector_param;
  import seqdet_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             seqIn = 1'b0;
  logic             in_valid = 1'b0;
  logic             overlap_en = 1'b0;
  logic             cfg_we = 1'b0;
  pattern_t         cfg_pattern = '0;
  len_t             cfg_len = '0;
  logic             detected;
  len_t             progress;
  logic [CNT_W-1:0] match_count;

  always #5 clk = ~clk;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seqIn       (seqIn),
    .in_valid    (in_valid),
    .overlap_en  (overlap_en),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .detected    (detected),
    .progress    (progress),
    .match_count (match_count)
  );

  typedef struct {
    logic     r;
    logic     cw;
    pattern_t pat;
    len_t     len;
    logic     v;
    logic     b;
    logic     ov;
    logic     det;
    len_t     prog;
  } vec_t;

  typedef struct {
    logic             det;
    len_t             prog;
    logic [CNT_W-1:0] cnt;
    int               idx;
  } exp_t;

  exp_t             sb[$];
  vec_t             tbl[$];
  int               checks   = 0;
  int               failures = 0;
  int               step_no  = 0;
  logic [CNT_W-1:0] cnt_m    = '0;
  logic             last_det = 1'b0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic cw, input pattern_t pat,
                              input len_t len, input logic v, input logic b,
                              input logic ov, input logic det, input len_t prog);
    vec_t x;
    x.r = r; x.cw = cw; x.pat = pat; x.len = len; x.v = v; x.b = b;
    x.ov = ov; x.det = det; x.prog = prog;
    return x;
  endfunction

  function automatic vec_t rst_v();
    return mk(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endfunction

  function automatic vec_t cfg_v(input pattern_t pat, input len_t len);
    return mk(1'b0, 1'b1, pat, len, 1'b1, 1'b1, 1'b0, 1'b0, '0);
  endfunction

  function automatic vec_t bit_v(input logic b, input logic ov,
                                 input logic det, input len_t prog);
    return mk(1'b0, 1'b0, '0, '0, 1'b1, b, ov, det, prog);
  endfunction

  function automatic vec_t idle_v(input len_t prog);
    return mk(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, prog);
  endfunction

  // Drive one cycle on the falling edge, queue its expectation, then compare
  // just after the rising edge that consumes it.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst         = v.r;
    cfg_we      = v.cw;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    in_valid    = v.v;
    seqIn       = v.b;
    overlap_en  = v.ov;
`ifdef SEQDET_MATCH_CNT_EN
    if (v.r || v.cw) cnt_m = '0;
    else if (last_det && (cnt_m != '1)) cnt_m = cnt_m + 1'b1;
`endif
    last_det = v.det;
    e.det = v.det; e.prog = v.prog; e.cnt = cnt_m; e.idx = step_no;
    sb.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("detected",    e.idx, 32'(detected),    32'(e.det));
    check("progress",    e.idx, 32'(progress),    32'(e.prog));
    check("match_count", e.idx, 32'(match_count), 32'(e.cnt));
  endtask

  initial begin
    // Default 1100 after reset, no overlap; pulse lasts one cycle.
    tbl.push_back(rst_v());
    tbl.push_back(bit_v(1, 0, 0, 1));
    tbl.push_back(bit_v(1, 0, 0, 2));
    tbl.push_back(bit_v(0, 0, 0, 3));
    tbl.push_back(bit_v(0, 0, 1, 0));
    tbl.push_back(idle_v(0));
    // 1011 with overlap: pulses after bits 4 and 7, border 10 retained.
    tbl.push_back(cfg_v(8'b0000_1011, 4));
    tbl.push_back(bit_v(1, 1, 0, 1));
    tbl.push_back(bit_v(0, 1, 0, 2));
    tbl.push_back(bit_v(1, 1, 0, 3));
    tbl.push_back(bit_v(1, 1, 1, 4));
    tbl.push_back(bit_v(0, 1, 0, 2));
    tbl.push_back(bit_v(1, 1, 0, 3));
    tbl.push_back(bit_v(1, 1, 1, 4));
    tbl.push_back(idle_v(4));
    // Same stream without overlap: only one pulse.
    tbl.push_back(cfg_v(8'b0000_1011, 4));
    tbl.push_back(bit_v(1, 0, 0, 1));
    tbl.push_back(bit_v(0, 0, 0, 2));
    tbl.push_back(bit_v(1, 0, 0, 3));
    tbl.push_back(bit_v(1, 0, 1, 0));
    tbl.push_back(bit_v(0, 0, 0, 0));
    tbl.push_back(bit_v(1, 0, 0, 1));
    tbl.push_back(bit_v(1, 0, 0, 1));
    // cfg_we mid-sequence discards the partial match.
    tbl.push_back(cfg_v(8'b0000_1100, 4));
    tbl.push_back(bit_v(1, 0, 0, 1));
    tbl.push_back(bit_v(1, 0, 0, 2));
    tbl.push_back(bit_v(0, 0, 0, 3));
    tbl.push_back(cfg_v(8'b0000_1100, 4));
    tbl.push_back(bit_v(0, 0, 0, 0));
    tbl.push_back(bit_v(1, 0, 0, 1));
    tbl.push_back(bit_v(1, 0, 0, 2));
    tbl.push_back(bit_v(0, 0, 0, 3));
    tbl.push_back(bit_v(0, 0, 1, 0));
    // rst mid-sequence discards the partial match.
    tbl.push_back(bit_v(1, 0, 0, 1));
    tbl.push_back(bit_v(1, 0, 0, 2));
    tbl.push_back(bit_v(0, 0, 0, 3));
    tbl.push_back(rst_v());
    tbl.push_back(bit_v(0, 0, 0, 0));
    // Length 2 "11" with overlap: back-to-back pulses.
    tbl.push_back(cfg_v(8'b0000_0011, 2));
    tbl.push_back(bit_v(1, 1, 0, 1));
    tbl.push_back(bit_v(1, 1, 1, 2));
    tbl.push_back(bit_v(1, 1, 1, 2));
    tbl.push_back(bit_v(0, 1, 0, 0));
    // Upper pattern bits ignored: 1111_0110 with len 3 means 110.
    tbl.push_back(cfg_v(8'b1111_0110, 3));
    tbl.push_back(bit_v(1, 0, 0, 1));
    tbl.push_back(bit_v(1, 0, 0, 2));
    tbl.push_back(bit_v(0, 0, 1, 0));
    // Length 15 clamps to 8: full-width pattern 1010_0101 matches.
    tbl.push_back(cfg_v(8'b1010_0101, 15));
    tbl.push_back(bit_v(1, 0, 0, 1));
    tbl.push_back(bit_v(0, 0, 0, 2));
    tbl.push_back(bit_v(1, 0, 0, 3));
    tbl.push_back(bit_v(0, 0, 0, 4));
    tbl.push_back(bit_v(0, 0, 0, 5));
    tbl.push_back(bit_v(1, 0, 0, 6));
    tbl.push_back(bit_v(0, 0, 0, 7));
    tbl.push_back(bit_v(1, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Input-valid gaps of three cycles between the bits of 1100.
    begin
      logic bits [4];
      len_t progs [4];
      bits[0] = 1; bits[1] = 1; bits[2] = 0; bits[3] = 0;
      progs[0] = 1; progs[1] = 2; progs[2] = 3; progs[3] = 0;
      step(rst_v());
      for (int i = 0; i < 4; i++) begin
        step(bit_v(bits[i], 0, (i == 3), progs[i]));
        for (int g = 0; g < 3; g++) step(idle_v(progs[i]));
      end
    end

    // Zero length disables detection for any stream.
    step(cfg_v(8'b0000_0000, 0));
    for (int i = 0; i < 24; i++) begin
      step(bit_v(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0));
    end

    // Five matches of 1100 then a reconfigure; exercises counter saturation.
    step(rst_v());
    for (int m = 0; m < 5; m++) begin
      step(bit_v(1, 0, 0, 1));
      step(bit_v(1, 0, 0, 2));
      step(bit_v(0, 0, 0, 3));
      step(bit_v(0, 0, 1, 0));
    end
    step(idle_v(0));
    step(idle_v(0));
    step(cfg_v(8'b0000_1100, 4));

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
